// File: rtl/buffer_fifo_configurable.sv
// Byte-wide FIFO whose depth (2..256 entries) is chosen at run time.
// The depth code is latched by save_config. Until a code has been saved,
// push and pop are ignored and no_config is high.
module buffer_fifo_configurable (
    input  logic       clk,
    input  logic       reset_data,
    input  logic       reset_config,
    input  logic       push,
    input  logic       pop,
    input  logic [7:0] data_in,
    input  logic [2:0] configuration,
    input  logic       save_config,
    output logic [7:0] data_out,
    output logic       buffer_full,
    output logic       no_config
);

    // Configuration state
    logic [2:0] config_reg;
    logic       cfg_valid;

    // Storage and FIFO bookkeeping
    logic [7:0] mem [0:255];
    logic [7:0] wr_ptr;
    logic [7:0] rd_ptr;
    logic [8:0] count;

    // Derived control
    logic [8:0] depth;
    logic [8:0] last_index;
    logic       active;
    logic       do_push;
    logic       do_pop;
    logic [7:0] wr_ptr_next;
    logic [7:0] rd_ptr_next;

    assign depth      = 9'd2 << config_reg;
    assign last_index = depth - 9'd1;

    // A save cycle discards the queue, so traffic in that same cycle is ignored.
    assign active = cfg_valid && !save_config;

    // Pop needs data. Push needs a free slot, or a pop in the same cycle that frees one.
    assign do_pop  = active && pop && (count != 9'd0);
    assign do_push = active && push && ((count < depth) || do_pop);

    // Both pointers wrap at the configured depth, not at the storage size.
    assign wr_ptr_next = ({1'b0, wr_ptr} == last_index) ? 8'd0 : wr_ptr + 8'd1;
    assign rd_ptr_next = ({1'b0, rd_ptr} == last_index) ? 8'd0 : rd_ptr + 8'd1;

    assign buffer_full = cfg_valid && (count == depth);
    assign no_config   = !cfg_valid;

    // Configuration register: only reset_config clears it.
    // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset_config) begin
        if (reset_config) begin
            config_reg <= 3'd0;
            cfg_valid  <= 1'b0;
        end else if (save_config) begin
            config_reg <= configuration;
            cfg_valid  <= 1'b1;
        end
    end

    // Pointers, occupancy and output register: either reset clears them.
    always_ff @(posedge clk or posedge reset_data or posedge reset_config) begin
        if (reset_data || reset_config) begin
            wr_ptr   <= 8'd0;
            rd_ptr   <= 8'd0;
            count    <= 9'd0;
            data_out <= 8'd0;
        end else if (save_config) begin
            wr_ptr <= 8'd0;
            rd_ptr <= 8'd0;
            count  <= 9'd0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr_next;
            end
            if (do_pop) begin
                rd_ptr   <= rd_ptr_next;
                data_out <= mem[rd_ptr];
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 9'd1;
                2'b01:   count <= count - 9'd1;
                default: count <= count;
            endcase
        end
    end

    // Storage array write port.
    // NOTE: the memory has no reset; the pointers and count decide which entries are valid, so old contents are never visible.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= data_in;
        end
    end

endmodule

// File: tb/tb_buffer_fifo_configurable.sv
// Self-checking bench for buffer_fifo_configurable.
// It applies a table of single-cycle vectors and then runs hand-written
// sequences for the long fill, the asynchronous resets and the 256-deep case.
module tb_buffer_fifo_configurable;

    logic       clk;
    logic       reset_data;
    logic       reset_config;
    logic       push;
    logic       pop;
    logic [7:0] data_in;
    logic [2:0] configuration;
    logic       save_config;
    logic [7:0] data_out;
    logic       buffer_full;
    logic       no_config;

    int checks = 0;
    int errors = 0;

    buffer_fifo_configurable dut (
        .clk          (clk),
        .reset_data   (reset_data),
        .reset_config (reset_config),
        .push         (push),
        .pop          (pop),
        .data_in      (data_in),
        .configuration(configuration),
        .save_config  (save_config),
        .data_out     (data_out),
        .buffer_full  (buffer_full),
        .no_config    (no_config)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       push;
        logic       pop;
        logic [7:0] din;
        logic       save;
        logic [2:0] cfg;
        logic [7:0] exp_dout;
        logic       exp_full;
        logic       exp_nocfg;
    } vec_t;

    localparam int NVEC = 31;
    vec_t vecs [NVEC];

    task automatic check(input string name, input logic [8:0] actual, input logic [8:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Drives one cycle of strobes and returns 1 time unit after the edge, which is when outputs are sampled.
    task automatic do_cycle(input logic p_push, input logic p_pop, input logic [7:0] d,
                            input logic p_save, input logic [2:0] c);
        push          = p_push;
        pop           = p_pop;
        data_in       = d;
        save_config   = p_save;
        configuration = c;
        @(posedge clk);
        #1;
        push        = 1'b0;
        pop         = 1'b0;
        save_config = 1'b0;
    endtask

    task automatic check_outputs(input string tag, input logic [7:0] dout, input logic full, input logic nocfg);
        check({tag, ".data_out"},    {1'b0, data_out}, {1'b0, dout});
        check({tag, ".buffer_full"}, {8'd0, buffer_full}, {8'd0, full});
        check({tag, ".no_config"},   {8'd0, no_config}, {8'd0, nocfg});
    endtask

    initial begin
        logic [7:0] b;

        // Fields: push, pop, din, save, cfg, exp_dout, exp_full, exp_nocfg.
        // Unconfigured: all traffic ignored.
        vecs[0]  = '{1'b1, 1'b0, 8'h55, 1'b0, 3'd0, 8'h00, 1'b0, 1'b1};
        vecs[1]  = '{1'b1, 1'b0, 8'h55, 1'b0, 3'd0, 8'h00, 1'b0, 1'b1};
        vecs[2]  = '{1'b1, 1'b0, 8'h55, 1'b0, 3'd0, 8'h00, 1'b0, 1'b1};
        vecs[3]  = '{1'b0, 1'b1, 8'h00, 1'b0, 3'd0, 8'h00, 1'b0, 1'b1};
        // Depth 2 wrap-around.
        vecs[4]  = '{1'b0, 1'b0, 8'h00, 1'b1, 3'd0, 8'h00, 1'b0, 1'b0};
        vecs[5]  = '{1'b1, 1'b0, 8'hA1, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0};
        vecs[6]  = '{1'b1, 1'b0, 8'hB2, 1'b0, 3'd0, 8'h00, 1'b1, 1'b0};
        vecs[7]  = '{1'b0, 1'b1, 8'h00, 1'b0, 3'd0, 8'hA1, 1'b0, 1'b0};
        vecs[8]  = '{1'b1, 1'b0, 8'hC3, 1'b0, 3'd0, 8'hA1, 1'b1, 1'b0};
        vecs[9]  = '{1'b0, 1'b1, 8'h00, 1'b0, 3'd0, 8'hB2, 1'b0, 1'b0};
        vecs[10] = '{1'b0, 1'b1, 8'h00, 1'b0, 3'd0, 8'hC3, 1'b0, 1'b0};
        vecs[11] = '{1'b0, 1'b1, 8'h00, 1'b0, 3'd0, 8'hC3, 1'b0, 1'b0};
        // Push and pop while empty: only the push happens.
        vecs[12] = '{1'b1, 1'b1, 8'hD4, 1'b0, 3'd0, 8'hC3, 1'b0, 1'b0};
        vecs[13] = '{1'b0, 1'b1, 8'h00, 1'b0, 3'd0, 8'hD4, 1'b0, 1'b0};
        vecs[14] = '{1'b0, 1'b1, 8'h00, 1'b0, 3'd0, 8'hD4, 1'b0, 1'b0};
        // Depth 4: fill, then push and pop together while full.
        vecs[15] = '{1'b0, 1'b0, 8'h00, 1'b1, 3'd1, 8'hD4, 1'b0, 1'b0};
        vecs[16] = '{1'b1, 1'b0, 8'h10, 1'b0, 3'd1, 8'hD4, 1'b0, 1'b0};
        vecs[17] = '{1'b1, 1'b0, 8'h11, 1'b0, 3'd1, 8'hD4, 1'b0, 1'b0};
        vecs[18] = '{1'b1, 1'b0, 8'h12, 1'b0, 3'd1, 8'hD4, 1'b0, 1'b0};
        vecs[19] = '{1'b1, 1'b0, 8'h13, 1'b0, 3'd1, 8'hD4, 1'b1, 1'b0};
        vecs[20] = '{1'b1, 1'b1, 8'h14, 1'b0, 3'd1, 8'h10, 1'b1, 1'b0};
        vecs[21] = '{1'b0, 1'b1, 8'h00, 1'b0, 3'd1, 8'h11, 1'b0, 1'b0};
        vecs[22] = '{1'b1, 1'b0, 8'h15, 1'b0, 3'd1, 8'h11, 1'b1, 1'b0};
        vecs[23] = '{1'b1, 1'b0, 8'h99, 1'b0, 3'd1, 8'h11, 1'b1, 1'b0};
        vecs[24] = '{1'b0, 1'b1, 8'h00, 1'b0, 3'd1, 8'h12, 1'b0, 1'b0};
        vecs[25] = '{1'b0, 1'b1, 8'h00, 1'b0, 3'd1, 8'h13, 1'b0, 1'b0};
        vecs[26] = '{1'b0, 1'b1, 8'h00, 1'b0, 3'd1, 8'h14, 1'b0, 1'b0};
        vecs[27] = '{1'b0, 1'b1, 8'h00, 1'b0, 3'd1, 8'h15, 1'b0, 1'b0};
        vecs[28] = '{1'b0, 1'b1, 8'h00, 1'b0, 3'd1, 8'h15, 1'b0, 1'b0};
        // A push in the same cycle as save_config is ignored.
        vecs[29] = '{1'b1, 1'b0, 8'h77, 1'b1, 3'd1, 8'h15, 1'b0, 1'b0};
        vecs[30] = '{1'b0, 1'b1, 8'h00, 1'b0, 3'd1, 8'h15, 1'b0, 1'b0};

        push          = 1'b0;
        pop           = 1'b0;
        data_in       = 8'h00;
        configuration = 3'd0;
        save_config   = 1'b0;
        reset_data    = 1'b1;
        reset_config  = 1'b1;
        #12;
        reset_data   = 1'b0;
        reset_config = 1'b0;
        @(posedge clk);
        #1;
        check_outputs("reset", 8'h00, 1'b0, 1'b1);

        for (int i = 0; i < NVEC; i++) begin
            do_cycle(vecs[i].push, vecs[i].pop, vecs[i].din, vecs[i].save, vecs[i].cfg);
            check_outputs($sformatf("vec%0d", i), vecs[i].exp_dout, vecs[i].exp_full, vecs[i].exp_nocfg);
        end

        // Depth 8: 260 pushes spaced every 3 cycles; only the first 8 are stored.
        do_cycle(1'b0, 1'b0, 8'h00, 1'b1, 3'd2);
        for (int k = 0; k < 260; k++) begin
            b = (k == 0) ? 8'd1 : 8'(k - 1);
            do_cycle(1'b1, 1'b0, b, 1'b0, 3'd2);
            if (k == 6) check("c2.full_after_7", {8'd0, buffer_full}, 9'd0);
            if (k == 7) check("c2.full_after_8", {8'd0, buffer_full}, 9'd1);
            do_cycle(1'b0, 1'b0, 8'h00, 1'b0, 3'd2);
            do_cycle(1'b0, 1'b0, 8'h00, 1'b0, 3'd2);
        end
        check("c2.full_after_all", {8'd0, buffer_full}, 9'd1);
        for (int k = 0; k < 5; k++) begin
            do_cycle(1'b0, 1'b1, 8'h00, 1'b0, 3'd2);
            b = (k == 0) ? 8'd1 : 8'(k - 1);
            check($sformatf("c2.pop%0d", k), {1'b0, data_out}, {1'b0, b});
            if (k == 0) check("c2.full_after_pop", {8'd0, buffer_full}, 9'd0);
        end

        // reset_data with 3 entries queued: clears at once, configuration survives.
        #3;
        reset_data = 1'b1;
        #1;
        check("rd.data_out_async", {1'b0, data_out}, 9'd0);
        reset_data = 1'b0;
        check("rd.no_config", {8'd0, no_config}, 9'd0);
        @(posedge clk);
        #1;
        do_cycle(1'b0, 1'b1, 8'h00, 1'b0, 3'd2);
        check("rd.pop_ignored", {1'b0, data_out}, 9'd0);
        for (int k = 0; k < 8; k++) begin
            do_cycle(1'b1, 1'b0, 8'(8'h40 + k), 1'b0, 3'd2);
        end
        check("rd.depth_kept", {8'd0, buffer_full}, 9'd1);
        do_cycle(1'b0, 1'b1, 8'h00, 1'b0, 3'd2);
        check("rd.first_after", {1'b0, data_out}, 9'h040);

        // reset_config mid-cycle: flags and data_out change before any clock edge.
        #3;
        reset_config = 1'b1;
        #1;
        check("rc.no_config_async", {8'd0, no_config}, 9'd1);
        check("rc.full_async", {8'd0, buffer_full}, 9'd0);
        check("rc.data_out_async", {1'b0, data_out}, 9'd0);
        reset_config = 1'b0;
        @(posedge clk);
        #1;
        do_cycle(1'b1, 1'b0, 8'h12, 1'b0, 3'd0);
        do_cycle(1'b0, 1'b1, 8'h00, 1'b0, 3'd0);
        check("rc.unconfigured_pop", {1'b0, data_out}, 9'd0);

        // Depth 256: fill completely, then drain in order.
        do_cycle(1'b0, 1'b0, 8'h00, 1'b1, 3'd7);
        for (int k = 0; k < 256; k++) begin
            do_cycle(1'b1, 1'b0, 8'(k ^ 8'h5A), 1'b0, 3'd7);
            if (k == 254) check("c7.full_after_255", {8'd0, buffer_full}, 9'd0);
        end
        check("c7.full_after_256", {8'd0, buffer_full}, 9'd1);
        for (int k = 0; k < 256; k++) begin
            do_cycle(1'b0, 1'b1, 8'h00, 1'b0, 3'd7);
            check($sformatf("c7.pop%0d", k), {1'b0, data_out}, {1'b0, 8'(k ^ 8'h5A)});
            if (k == 0) check("c7.full_after_pop", {8'd0, buffer_full}, 9'd0);
        end
        do_cycle(1'b0, 1'b1, 8'h00, 1'b0, 3'd7);
        check("c7.empty_pop_holds", {1'b0, data_out}, {1'b0, 8'(255 ^ 8'h5A)});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
